mdu_unit: RTL

Parametrised multiply/divide unit with private HI/LO registers. It is the sequential arithmetic companion to the ALU for the pipelined MIPS core. It executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo. Operand width and per-operation latency are configurable. A busy output lets the hazard unit stall dependent instructions.

---
 rtl/mdu_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mdu_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_unit : multi-cycle multiply/divide unit with private HI/LO registers
// Rev 1.0
// ---------------------------------------------------------------------------
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       MDUOP,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MDUOut
);

  localparam int C_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CNT_W   = $clog2(C_MAX_CYC + 1);

  localparam logic [C_CNT_W-1:0] C_MULT_LOAD = C_CNT_W'(MULT_CYCLES);
  localparam logic [C_CNT_W-1:0] C_DIV_LOAD  = C_CNT_W'(DIV_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

  localparam logic [3:0] C_OP_MULT  = 4'd1;
  localparam logic [3:0] C_OP_MULTU = 4'd2;
  localparam logic [3:0] C_OP_DIV   = 4'd3;
  localparam logic [3:0] C_OP_DIVU  = 4'd4;
  localparam logic [3:0] C_OP_MTHI  = 4'd5;
  localparam logic [3:0] C_OP_MTLO  = 4'd6;
  localparam logic [3:0] C_OP_MFHI  = 4'd7;
  localparam logic [3:0] C_OP_MFLO  = 4'd8;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_pend_hi;
  logic [WIDTH-1:0]   r_pend_lo;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_busy;
  logic               r_commit;

  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;

  logic               w_div_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_b_safe;
  logic [WIDTH-1:0]   w_q_mag;
  logic [WIDTH-1:0]   w_r_mag;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  // Low 2*WIDTH bits of the product of sign- or zero-extended operands
  // give the correct signed or unsigned full-width result.
  always_comb begin
    if (MDUOP == C_OP_MULT) begin
      w_a_ext = {{WIDTH{SrcA[WIDTH-1]}}, SrcA};
      w_b_ext = {{WIDTH{SrcB[WIDTH-1]}}, SrcB};
    end else begin
      w_a_ext = {{WIDTH{1'b0}}, SrcA};
      w_b_ext = {{WIDTH{1'b0}}, SrcB};
    end
    w_prod = w_a_ext * w_b_ext;
  end

  // Magnitude division: most-negative / -1 naturally yields most-negative
  // with zero remainder, and a zero divisor is replaced to keep results defined.
  always_comb begin
    w_div_signed = (MDUOP == C_OP_DIV);
    w_a_neg      = w_div_signed & SrcA[WIDTH-1];
    w_b_neg      = w_div_signed & SrcB[WIDTH-1];
    w_b_zero     = (SrcB == '0);
    w_a_mag      = w_a_neg ? (~SrcA + WIDTH'(1)) : SrcA;
    w_b_mag      = w_b_neg ? (~SrcB + WIDTH'(1)) : SrcB;
    w_b_safe     = w_b_zero ? WIDTH'(1) : w_b_mag;
    w_q_mag      = w_a_mag / w_b_safe;
    w_r_mag      = w_a_mag % w_b_safe;
    w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + WIDTH'(1)) : w_q_mag;
    w_rem        = w_a_neg ? (~w_r_mag + WIDTH'(1)) : w_r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_commit  <= 1'b0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - C_CNT_ONE;
      if (r_cnt == C_CNT_ONE) begin
        r_busy   <= 1'b0;
        r_commit <= 1'b0;
        if (r_commit) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end
    end else if (start) begin
      case (MDUOP)
        C_OP_MULT, C_OP_MULTU: begin
          r_pend_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_pend_lo <= w_prod[WIDTH-1:0];
          r_cnt     <= C_MULT_LOAD;
          r_busy    <= 1'b1;
          r_commit  <= 1'b1;
        end
        C_OP_DIV, C_OP_DIVU: begin
          r_pend_hi <= w_rem;
          r_pend_lo <= w_quot;
          r_cnt     <= C_DIV_LOAD;
          r_busy    <= 1'b1;
          r_commit  <= ~w_b_zero;
        end
        C_OP_MTHI: r_hi <= SrcA;
        C_OP_MTLO: r_lo <= SrcA;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (MDUOP)
      C_OP_MFHI: MDUOut = r_hi;
      C_OP_MFLO: MDUOut = r_lo;
      default:   MDUOut = '0;
    endcase
  end

  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
`default_nettype wire
